// File: rtl/srlzr_ctrl.sv
// Sequencer for a parallel-in/serial-out serializer: buffers one upstream
// word, pulses the PISO load, then enables WIDTH shift cycles per frame with
// first/last qualifiers, optional inter-frame gap and a completed-frame count.
module srlzr_ctrl #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned GAP    = 0,
    parameter int unsigned FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WIDTH-1:0]  s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              piso_load,
    output logic [WIDTH-1:0]  piso_data,
    output logic              piso_shift,
    output logic              tx_valid,
    output logic              tx_sof,
    output logic              tx_last,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int unsigned BIT_W = $clog2(WIDTH);
    localparam int unsigned GAP_W = 4;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    // Only compared while in the gap state, which is unreachable when GAP is 0.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [BIT_W-1:0]   bit_cnt_nxt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_cnt_nxt;
    logic               frame_inc;
    logic               hold_full;
    logic [WIDTH-1:0]   hold_data;
    logic               rdy_en;
    logic               accept;

    assign accept = s_valid & s_ready;

    // State and frame-position counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        gap_cnt_nxt = gap_cnt;
        frame_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hold_full && en) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                state_nxt   = ST_SHIFT;
                bit_cnt_nxt = '0;
            end
            ST_SHIFT: begin
                bit_cnt_nxt = bit_cnt + 1'b1;
                if (bit_cnt == BIT_LAST) begin
                    frame_inc   = 1'b1;
                    bit_cnt_nxt = '0;
                    if (GAP != 0) begin
                        state_nxt   = ST_GAP;
                        gap_cnt_nxt = '0;
                    end else if (hold_full && en) begin
                        state_nxt = ST_LOAD;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                gap_cnt_nxt = gap_cnt + 1'b1;
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = (hold_full && en) ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // One-word holding register; the held word drains on LOAD unless refilled.
    // rdy_en keeps s_ready low until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            rdy_en    <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (accept) begin
                hold_data <= s_data;
                hold_full <= 1'b1;
            end else if (state == ST_LOAD) begin
                hold_full <= 1'b0;
            end
        end
    end

    // Completed-frame counter, wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_inc) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // Strobes decoded from registered state only.
    assign s_ready    = rdy_en & (~hold_full | (state == ST_LOAD));
    assign piso_load  = (state == ST_LOAD);
    assign piso_data  = {WIDTH{piso_load}} & hold_data;
    assign piso_shift = (state == ST_SHIFT);
    assign tx_valid   = (state == ST_SHIFT);
    assign tx_sof     = (state == ST_SHIFT) && (bit_cnt == '0);
    assign tx_last    = (state == ST_SHIFT) && (bit_cnt == BIT_LAST);
    assign busy       = (state != ST_IDLE) | hold_full;

endmodule

// File: tb/tb_srlzr_ctrl.sv
// Directed bench for srlzr_ctrl: three instances sharing inputs
// (u0: GAP=0/FCNT_W=16, u1: GAP=2, u2: FCNT_W=4).
module tb_srlzr_ctrl;

    logic            clk;
    logic            rst;
    logic            en;
    logic [3:0]      s_data;
    logic            s_valid;
    logic [2:0]      rdy_v, load_v, shift_v, valid_v, sof_v, last_v, busy_v;
    logic [2:0][3:0] pdata_v;
    logic [15:0]     fc0, fc1;
    logic [3:0]      fc2;

    int n_checks = 0;
    int n_fail   = 0;

    // Stream recorder state
    logic [3:0] words [32];
    int         load_cyc [32];
    logic [3:0] load_dat [32];
    int         last_cyc [32];
    int         nload, nlast, nvalid, max_low;
    bit         done;

    srlzr_ctrl #(.WIDTH(4), .GAP(0), .FCNT_W(16)) u0 (
        .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid),
        .s_ready(rdy_v[0]), .piso_load(load_v[0]), .piso_data(pdata_v[0]),
        .piso_shift(shift_v[0]), .tx_valid(valid_v[0]), .tx_sof(sof_v[0]),
        .tx_last(last_v[0]), .busy(busy_v[0]), .frame_cnt(fc0));

    srlzr_ctrl #(.WIDTH(4), .GAP(2), .FCNT_W(16)) u1 (
        .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid),
        .s_ready(rdy_v[1]), .piso_load(load_v[1]), .piso_data(pdata_v[1]),
        .piso_shift(shift_v[1]), .tx_valid(valid_v[1]), .tx_sof(sof_v[1]),
        .tx_last(last_v[1]), .busy(busy_v[1]), .frame_cnt(fc1));

    srlzr_ctrl #(.WIDTH(4), .GAP(0), .FCNT_W(4)) u2 (
        .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid),
        .s_ready(rdy_v[2]), .piso_load(load_v[2]), .piso_data(pdata_v[2]),
        .piso_shift(shift_v[2]), .tx_valid(valid_v[2]), .tx_sof(sof_v[2]),
        .tx_last(last_v[2]), .busy(busy_v[2]), .frame_cnt(fc2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = 4'd0;
        step();
        rst = 1'b0;
        step();
    endtask

    // Feed words[0..n-1] through instance sel's handshake and record strobes.
    task automatic stream(input int sel, input int n, input int maxc);
        int idx = 0;
        int low = 0;
        bit go;
        nload = 0; nlast = 0; nvalid = 0; max_low = 0; done = 1'b0;
        s_data  = words[0];
        s_valid = 1'b1;
        for (int c = 0; c < maxc; c++) begin
            if (load_v[sel] && nload < 32) begin
                load_cyc[nload] = c; load_dat[nload] = pdata_v[sel]; nload++;
            end
            if (last_v[sel] && nlast < 32) begin
                last_cyc[nlast] = c; nlast++;
            end
            if (valid_v[sel]) nvalid++;
            if (!rdy_v[sel]) begin
                low++;
                if (low > max_low) max_low = low;
            end else begin
                low = 0;
            end
            go = s_valid && rdy_v[sel];
            step();
            if (go) begin
                idx++;
                if (idx < n) s_data = words[idx];
                else s_valid = 1'b0;
            end
            if (idx >= n && nlast >= n && !busy_v[sel]) begin
                done = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = 4'd0;
        step();
        n_checks++;
        if ({rdy_v[0], load_v[0], shift_v[0], valid_v[0], sof_v[0], last_v[0], busy_v[0]} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 0000000",
                     {rdy_v[0], load_v[0], shift_v[0], valid_v[0], sof_v[0], last_v[0], busy_v[0]});
        end
        n_checks++;
        if (pdata_v[0] !== 4'd0 || fc0 !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_data: piso_data=%h frame_cnt=%0d expected 0/0", pdata_v[0], fc0);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (rdy_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b expected 0", rdy_v[0]);
        end
        step();
        n_checks++;
        if (rdy_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_edge: got %b expected 1", rdy_v[0]);
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        en = 1'b1; s_data = 4'b1011; s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        n_checks++;
        if (rdy_v[0] !== 1'b0 || busy_v[0] !== 1'b1 || load_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_held: ready=%b busy=%b load=%b expected 0/1/0", rdy_v[0], busy_v[0], load_v[0]);
        end
        step();
        n_checks++;
        if (load_v[0] !== 1'b1 || pdata_v[0] !== 4'b1011 || valid_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_load: load=%b data=%b valid=%b expected 1/1011/0", load_v[0], pdata_v[0], valid_v[0]);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if ({valid_v[0], shift_v[0], sof_v[0], last_v[0], load_v[0]} !== {2'b11, i == 0, i == 3, 1'b0}) begin
                n_fail++;
                $display("FAIL t1_shift%0d: valid/shift/sof/last/load=%b expected %b", i,
                         {valid_v[0], shift_v[0], sof_v[0], last_v[0], load_v[0]}, {2'b11, i == 0, i == 3, 1'b0});
            end
        end
        step();
        n_checks++;
        if (valid_v[0] !== 1'b0 || fc0 !== 16'd1 || busy_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_end: valid=%b frame_cnt=%0d busy=%b expected 0/1/0", valid_v[0], fc0, busy_v[0]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        en = 1'b1;
        words[0] = 4'b0001; words[1] = 4'b0010; words[2] = 4'b0011;
        stream(0, 3, 60);
        n_checks++;
        if (!done || nload !== 3) begin
            n_fail++;
            $display("FAIL t2_loads: done=%0d loads=%0d expected 1/3", done, nload);
        end else begin
            n_checks++;
            if (load_cyc[1] - load_cyc[0] !== 5 || load_cyc[2] - load_cyc[1] !== 5) begin
                n_fail++;
                $display("FAIL t2_spacing: got %0d,%0d expected 5,5",
                         load_cyc[1] - load_cyc[0], load_cyc[2] - load_cyc[1]);
            end
            n_checks++;
            if (load_dat[0] !== 4'b0001 || load_dat[1] !== 4'b0010 || load_dat[2] !== 4'b0011) begin
                n_fail++;
                $display("FAIL t2_data: got %b %b %b expected 0001 0010 0011", load_dat[0], load_dat[1], load_dat[2]);
            end
        end
        n_checks++;
        if (max_low > 4) begin
            n_fail++;
            $display("FAIL t2_ready_low: got %0d cycles expected <=4", max_low);
        end
        n_checks++;
        if (fc0 !== 16'd3) begin
            n_fail++;
            $display("FAIL t2_frame_cnt: got %0d expected 3", fc0);
        end
    endtask

    task automatic test_gap();
        do_reset();
        en = 1'b1;
        words[0] = 4'b0101; words[1] = 4'b1010;
        stream(1, 2, 60);
        n_checks++;
        if (!done || nload !== 2 || nlast !== 2 || nvalid !== 8) begin
            n_fail++;
            $display("FAIL t3_counts: done=%0d loads=%0d lasts=%0d valids=%0d expected 1/2/2/8",
                     done, nload, nlast, nvalid);
        end else begin
            n_checks++;
            if (load_cyc[1] - last_cyc[0] !== 3) begin
                n_fail++;
                $display("FAIL t3_gap: last-to-load distance %0d expected 3", load_cyc[1] - last_cyc[0]);
            end
            n_checks++;
            if (load_dat[1] !== 4'b1010) begin
                n_fail++;
                $display("FAIL t3_data: got %b expected 1010", load_dat[1]);
            end
        end
        n_checks++;
        if (fc1 !== 16'd2) begin
            n_fail++;
            $display("FAIL t3_frame_cnt: got %0d expected 2", fc1);
        end
    endtask

    task automatic test_enable_drop();
        bit seen_last = 1'b0;
        bit seen_load = 1'b0;
        do_reset();
        en = 1'b1; s_data = 4'b1100; s_valid = 1'b1;
        step();                     // A accepted, IDLE with word held
        s_data = 4'b0110;
        step();                     // LOAD, s_ready high
        step();                     // SHIFT bit0, B accepted
        s_valid = 1'b0;
        step();                     // SHIFT bit1
        en = 1'b0;
        n_checks++;
        if (valid_v[0] !== 1'b1 || sof_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_second_shift: valid=%b sof=%b expected 1/0", valid_v[0], sof_v[0]);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (last_v[0]) seen_last = 1'b1;
            if (load_v[0]) seen_load = 1'b1;
        end
        n_checks++;
        if (seen_last !== 1'b1 || seen_load !== 1'b0 || fc0 !== 16'd1 || busy_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL t4_hold: last=%0d load=%0d frame_cnt=%0d busy=%b expected 1/0/1/1",
                     seen_last, seen_load, fc0, busy_v[0]);
        end
        en = 1'b1;
        seen_load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (load_v[0] && !seen_load) begin
                seen_load = 1'b1;
                n_checks++;
                if (pdata_v[0] !== 4'b0110) begin
                    n_fail++;
                    $display("FAIL t4_resume_data: got %b expected 0110", pdata_v[0]);
                end
            end
        end
        n_checks++;
        if (seen_load !== 1'b1) begin
            n_fail++;
            $display("FAIL t4_resume: load seen=%0d expected 1 within 2 cycles", seen_load);
        end
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_reset_mid_frame();
        bit seen_load = 1'b0;
        int vcount = 0;
        do_reset();
        en = 1'b1; s_data = 4'b1010; s_valid = 1'b1;
        step();                     // accepted
        s_data = 4'b0110;
        step();                     // LOAD
        step();                     // SHIFT bit0, second word buffered
        s_valid = 1'b0;
        step();                     // SHIFT bit1
        step();                     // SHIFT bit2
        n_checks++;
        if (valid_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_pre: valid=%b expected 1", valid_v[0]);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({rdy_v[0], load_v[0], shift_v[0], valid_v[0], sof_v[0], last_v[0], busy_v[0]} !== 7'b0 ||
            fc0 !== 16'd0) begin
            n_fail++;
            $display("FAIL t5_abort: strobes=%b frame_cnt=%0d expected 0000000/0",
                     {rdy_v[0], load_v[0], shift_v[0], valid_v[0], sof_v[0], last_v[0], busy_v[0]}, fc0);
        end
        step();
        rst = 1'b0;
        step();
        s_data = 4'b1111; s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        for (int i = 0; i < 4 && !seen_load; i++) begin
            step();
            if (load_v[0]) begin
                seen_load = 1'b1;
                n_checks++;
                if (pdata_v[0] !== 4'b1111) begin
                    n_fail++;
                    $display("FAIL t5_data: got %b expected 1111", pdata_v[0]);
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (valid_v[0]) vcount++;
        end
        n_checks++;
        if (seen_load !== 1'b1 || vcount !== 4 || fc0 !== 16'd1 || busy_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_after: load=%0d valids=%0d frame_cnt=%0d busy=%b expected 1/4/1/0",
                     seen_load, vcount, fc0, busy_v[0]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 17; i++) words[i] = 4'(i);
        stream(2, 17, 200);
        n_checks++;
        if (!done || nload !== 17) begin
            n_fail++;
            $display("FAIL t6_done: done=%0d loads=%0d expected 1/17", done, nload);
        end
        n_checks++;
        if (fc2 !== 4'd1 || fc0 !== 16'd17) begin
            n_fail++;
            $display("FAIL t6_wrap: narrow=%0d wide=%0d expected 1/17", fc2, fc0);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = 4'd0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gap();
        test_enable_drop();
        test_reset_mid_frame();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
